// File: rtl/shift_result_fifo.sv
// shift_result_fifo: first-word-fall-through FIFO of shift/rotate results with flags captured at push
//   clk, rst_n                               : clock, asynchronous active-low reset
//   in_valid/in_ready/in_result/in_op/in_amount : producer handshake and result fields
//   out_valid/out_ready                      : consumer handshake for the head entry
//   out_result/out_op/out_zero/out_neg/out_nop : head entry fields, all zero when empty
//   count                                    : number of stored entries
module shift_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_result,
  input  logic [2:0]             in_op,
  input  logic [4:0]             in_amount,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [2:0]             out_op,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic                   out_nop,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]      r_result [DEPTH];
  logic [2:0]       r_op [DEPTH];
  logic [DEPTH-1:0] r_zero, r_neg, r_nop;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;
  // rst_n gates in_ready so the producer sees no room while reset is held
  assign in_ready   = rst_n & (r_count < FULL);
  assign out_valid  = (r_count != '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign count      = r_count;
  assign out_result = out_valid ? r_result[r_rptr] : '0;
  assign out_op     = out_valid ? r_op[r_rptr] : '0;
  assign out_zero   = out_valid & r_zero[r_rptr];
  assign out_neg    = out_valid & r_neg[r_rptr];
  assign out_nop    = out_valid & r_nop[r_rptr];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_zero  <= '0;
      r_neg   <= '0;
      r_nop   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_result[i] <= '0;
        r_op[i]     <= '0;
      end
    end else begin
      if (w_push) begin
        r_result[r_wptr] <= in_result;
        r_op[r_wptr]     <= in_op;
        r_zero[r_wptr]   <= (in_result == '0);
        r_neg[r_wptr]    <= in_result[31];
        r_nop[r_wptr]    <= (in_amount == '0);
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_shift_result_fifo.sv
// tb_shift_result_fifo: vector table, corner sequences and queue-model random test for shift_result_fifo
module tb_shift_result_fifo;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_amount = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_op;
  logic        out_zero, out_neg, out_nop;
  logic [2:0]  count;
  int          n_tests = 0;
  int          n_fail = 0;

  shift_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op), .in_amount(in_amount),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .out_nop(out_nop), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic ordy; logic [31:0] res; logic [2:0] op; logic [4:0] amt;
    logic ev; logic erdy; logic [31:0] eres; logic [2:0] eop; logic ez; logic en; logic enop; logic [2:0] ecnt;
  } vec_t;
  typedef struct { logic [31:0] res; logic [2:0] op; logic [4:0] amt; } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic erdy, input logic [31:0] eres,
                         input logic [2:0] eop, input logic ez, input logic en, input logic enop,
                         input logic [2:0] ecnt);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(erdy));
    chk({nm, ".out_result"}, out_result, eres);
    chk({nm, ".out_op"}, 32'(out_op), 32'(eop));
    chk({nm, ".out_zero"}, 32'(out_zero), 32'(ez));
    chk({nm, ".out_neg"}, 32'(out_neg), 32'(en));
    chk({nm, ".out_nop"}, 32'(out_nop), 32'(enop));
    chk({nm, ".count"}, 32'(count), 32'(ecnt));
  endtask

  initial begin
    vec_t        vecs[11];
    ent_t        q[$];
    ent_t        h, e;
    logic [31:0] got[$];
    logic [31:0] pv;
    logic        pushed, popped, mv, mpush, mpop;
    int          nv, maxc;
    vecs[0]  = '{1'b1, 1'b0, 32'hF000_0000, 3'd1, 5'd4,  1'b1, 1'b1, 32'hF000_0000, 3'd1, 1'b0, 1'b1, 1'b0, 3'd1};
    vecs[1]  = '{1'b0, 1'b1, 32'h0,         3'd0, 5'd0,  1'b0, 1'b1, 32'h0,         3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         3'd2, 5'd0,  1'b1, 1'b1, 32'h0,         3'd2, 1'b1, 1'b0, 1'b1, 3'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 3'd3, 5'd20, 1'b1, 1'b1, 32'h0,         3'd2, 1'b1, 1'b0, 1'b1, 3'd2};
    vecs[4]  = '{1'b0, 1'b1, 32'h0,         3'd0, 5'd0,  1'b1, 1'b1, 32'h7FFF_FFFF, 3'd3, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,         3'd0, 5'd0,  1'b0, 1'b1, 32'h0,         3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'hA,         3'd0, 5'd1,  1'b1, 1'b1, 32'hA,         3'd0, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[7]  = '{1'b1, 1'b0, 32'hB,         3'd5, 5'd2,  1'b1, 1'b1, 32'hA,         3'd0, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'hC,         3'd6, 5'd3,  1'b1, 1'b1, 32'hB,         3'd5, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[9]  = '{1'b0, 1'b1, 32'h0,         3'd0, 5'd0,  1'b1, 1'b1, 32'hC,         3'd6, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[10] = '{1'b0, 1'b1, 32'h0,         3'd0, 5'd0,  1'b0, 1'b1, 32'h0,         3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    #2;
    chk_out("reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    #5 rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      in_result = vecs[i].res; in_op = vecs[i].op; in_amount = vecs[i].amt;
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erdy, vecs[i].eres, vecs[i].eop,
              vecs[i].ez, vecs[i].en, vecs[i].enop, vecs[i].ecnt);
    end
    in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_amount = 5'd1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_result = 32'(k);
      @(posedge clk); #1;
    end
    in_result = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("fill_full", 1'b1, 1'b0, 32'd1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk_out($sformatf("fill_pop%0d", k), 1'b1, k != 1, 32'(k), 3'd0, 1'b0, 1'b0, 1'b0, 3'(5 - k));
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk_out("fill_empty", 1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    chk_out("pop_when_empty", 1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_result = 32'h21 + 32'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rstmid_pre_count", 32'(count), 32'd3);
    #3 rst_n = 1'b0;
    #1 chk_out("rstmid_async", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    chk_out("rstmid_held", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_result = 32'h14; in_op = 3'd0; in_amount = 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("rst_first_push", 1'b1, 1'b1, 32'h14, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nv = 0; maxc = 0;
    for (int c = 0; c < 200 && got.size() < 10; c++) begin
      in_valid = (nv < 10); in_result = 32'(nv); out_ready = 1'($urandom_range(0, 1));
      #1;
      if (int'(count) > maxc) maxc = int'(count);
      pushed = in_valid && in_ready; popped = out_valid && out_ready; pv = out_result;
      @(posedge clk); #1;
      if (pushed) nv++;
      if (popped) got.push_back(pv);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_count_out", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++) chk($sformatf("wrap_order%0d", i), got[i], 32'(i));
    chk("wrap_max_le_depth", 32'(maxc > DEPTH), 32'd0);
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: in_result = 32'h0;
        1: in_result = 32'h8000_0000 | $urandom;
        default: in_result = $urandom;
      endcase
      in_op = 3'($urandom);
      in_amount = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      #1;
      mv = (q.size() != 0);
      if (mv) h = q[0];
      else h = '{32'h0, 3'd0, 5'd0};
      chk_out("rand", mv, q.size() < DEPTH, mv ? h.res : 32'h0, mv ? h.op : 3'd0,
              mv && (h.res == 32'h0), mv && h.res[31], mv && (h.amt == 5'd0), 3'(q.size()));
      mpush = in_valid && (q.size() < DEPTH); mpop = out_ready && mv;
      e = '{in_result, in_op, in_amount};
      @(posedge clk); #1;
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(e);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_result_fifo.md
SHIFT_RESULT_FIFO -- requirements
Module: shift_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of result entries (power of two, >= 2).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  producer presents a shift/rotate result this cycle.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-006 The block SHALL have port in_result  input  32  result word from the shift/rotate unit.
REQ-007 The block SHALL have port in_op  input  3  operation code that produced in_result.
REQ-008 The block SHALL have port in_amount  input  5  shift/rotate amount that produced in_result.
REQ-009 The block SHALL have port out_valid  output  1  head entry available.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts head entry this cycle.
REQ-011 The block SHALL have port out_result  output  32  head entry result word.
REQ-012 The block SHALL have port out_op  output  3  head entry op code.
REQ-013 The block SHALL have port out_zero  output  1  head entry result equals 0.
REQ-014 The block SHALL have port out_neg  output  1  head entry result bit 31.
REQ-015 The block SHALL have port out_nop  output  1  head entry amount equals 0.
REQ-016 The block SHALL have port count  output  clog2(DEPTH)+1  number of stored entries.

Function
REQ-017 Push SHALL occur on a rising edge when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL equal (count < DEPTH), combinational from registered count; no pass-through when full, even if pop occurs the same cycle.
REQ-019 out_valid SHALL equal (count != 0); head fields SHALL be driven directly from head storage (first-word-fall-through).
REQ-020 Push-to-out_valid latency SHALL be 1 cycle; a push into an empty FIFO never appears combinationally on the same cycle.
REQ-021 Flags SHALL be computed at push and stored: zero = (in_result == 0), neg = in_result[31], nop = (in_amount == 0).
REQ-022 Write and read pointers SHALL be log2(DEPTH) bits, increment by 1 per push/pop, and wrap from DEPTH-1 to 0.
REQ-023 Simultaneous push and pop (count between 1 and DEPTH-1) SHALL leave count unchanged and preserve FIFO order.
REQ-024 Simultaneous push and pop with count=0 SHALL be impossible (out_valid=0); push alone takes effect.
REQ-025 in_valid while in_ready=0 SHALL NOT modify state; producer holds data until accepted.
REQ-026 Changes on out_ready while out_valid=0 SHALL have no effect.
REQ-027 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-028 When out_valid=0, out_result, out_op, out_zero, out_neg, out_nop SHALL be 0.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, clear pointers, count, all storage entries and stored flags.
REQ-030 During reset: out_valid=0, in_ready=0, out_result=0, out_op=0, out_zero=0, out_neg=0, out_nop=0, count=0.
REQ-031 Reset mid-operation SHALL discard all entries; first edge after rst_n rises accepts a push with in_ready=1.
REQ-032 Reset release SHALL be synchronous to clk; in_ready SHALL become 1 on the first cycle after release.

Verification
REQ-033 Single push: in_result=0xF0000000, op=001, amount=4, out_ready=0 -> next cycle out_valid=1, out_result=0xF0000000, out_neg=1, out_zero=0, out_nop=0, count=1.
REQ-034 Fill: 4 pushes (1,2,3,4) with out_ready=0, 5th in_valid held with 5 -> count=4, in_ready=0, fifth not stored; then 5 pops -> 1,2,3,4, then out_valid=0.
REQ-035 Concurrent: count=2 (0xA,0xB), push 0xC with pop same edge -> count=2, next pops return 0xB, 0xC.
REQ-036 Flags: push 0x00000000 amount=0, then 0x7FFFFFFF amount=20 -> first head zero=1, nop=1, neg=0; second zero=0, nop=0, neg=0.
REQ-037 Wrap: 10 push/pop pairs of values 0..9 with random out_ready stalls -> output order exactly 0..9, count never >4.
REQ-038 Reset mid-operation: count=3, drive rst_n=0 between edges -> out_valid=0, count=0, out_result=0 before next edge; after release, push 0x14 -> out_result=0x14.
